// File: rtl/k7_config_seq_pkg.sv
// Shared definitions for the K7 configuration sequencer: state encodings,
// error codes (as seen in the MCU register map) and a busy-state helper.
package k7_config_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PROG      = 3'd1,
        ST_WAIT_INIT = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RST_HOLD  = 3'd4,
        ST_RUN       = 3'd5,
        ST_ERR       = 3'd6,
        ST_FAIL      = 3'd7
    } cfg_state_e;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_INIT_TO  = 2'd1;
    localparam logic [1:0] ERR_INIT_LOW = 2'd2;
    localparam logic [1:0] ERR_DONE_TO  = 2'd3;

    function automatic logic is_busy(input cfg_state_e st);
        logic b;
        case (st)
            ST_PROG, ST_WAIT_INIT, ST_WAIT_DONE, ST_RST_HOLD: b = 1'b1;
            default:                                          b = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/k7_config_seq_sync_2ff.sv
// Two-flop synchroniser for one asynchronous input bit; RST_VAL sets the
// value presented while the domain is held in reset.
module k7_config_seq_sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic meta_q;
    (* ASYNC_REG = "TRUE" *) logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/k7_config_seq.sv
// K7 configuration sequencer: timed PROG_B pulse, INIT_B/DONE supervision with
// timeouts and bounded retry, and RST_B hold-off until configuration is complete.
module k7_config_seq
    import k7_config_seq_pkg::*;
#(
    parameter int unsigned PROG_PULSE_CYC   = 40,
    parameter int unsigned INIT_TIMEOUT_CYC = 40_000,
    parameter int unsigned DONE_TIMEOUT_CYC = 40_000_000,
    parameter int unsigned RST_HOLD_CYC     = 400,
    parameter int unsigned MAX_RETRY        = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mcu_prog_b,
    input  logic       mcu_rst_b,
    input  logic       init_b_k7,
    input  logic       done_k7,
    output logic       prog_b_k7,
    output logic       rst_b_k7,
    output logic       fpga_done,
    output logic       fpga_init_b,
    output logic       busy,
    output logic [1:0] err_code,
    output logic [2:0] retry_cnt
);

    // Counter reload values: a state lasting N cycles loads N-1 on entry.
    localparam logic [31:0] PROG_LOAD = 32'(PROG_PULSE_CYC - 1);
    localparam logic [31:0] INIT_LOAD = 32'(INIT_TIMEOUT_CYC - 1);
    localparam logic [31:0] DONE_LOAD = 32'(DONE_TIMEOUT_CYC - 1);
    localparam logic [31:0] HOLD_LOAD = 32'(RST_HOLD_CYC - 1);
    localparam logic [2:0]  RETRY_MAX = 3'(MAX_RETRY);

    logic prog_s, rst_b_s, init_s, done_s;

    k7_config_seq_sync_2ff #(.RST_VAL(1'b1)) u_sync_prog (.clk(clk), .rst(rst), .d(mcu_prog_b), .q(prog_s));
    k7_config_seq_sync_2ff #(.RST_VAL(1'b0)) u_sync_rstb (.clk(clk), .rst(rst), .d(mcu_rst_b),  .q(rst_b_s));
    k7_config_seq_sync_2ff #(.RST_VAL(1'b0)) u_sync_init (.clk(clk), .rst(rst), .d(init_b_k7),  .q(init_s));
    k7_config_seq_sync_2ff #(.RST_VAL(1'b0)) u_sync_done (.clk(clk), .rst(rst), .d(done_k7),    .q(done_s));

    cfg_state_e  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [1:0]  err_q, err_d;
    logic [2:0]  retry_q, retry_d;
    logic        prog_prev_q, prog_prev_d;
    logic        req_q, req_d;
    logic        prog_b_q, prog_b_d;
    logic        rst_b_q, rst_b_d;
    logic        done_q, done_d;
    logic        init_b_q, init_b_d;
    logic        busy_q, busy_d;

    // Next-state, shared down counter, error/retry bookkeeping and output decode.
    always_comb begin
        prog_prev_d = prog_s;
        req_d       = prog_prev_q & ~prog_s;
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        retry_d     = retry_q;

        case (state_q)
            ST_IDLE: begin
                if (req_q) begin
                    state_d = ST_PROG;
                    cnt_d   = PROG_LOAD;
                    err_d   = ERR_NONE;
                    retry_d = 3'd0;
                end else if (done_s) begin
                    state_d = ST_RST_HOLD;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PROG: begin
                if (cnt_q == 32'd0) begin
                    state_d = ST_WAIT_INIT;
                    cnt_d   = INIT_LOAD;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_WAIT_INIT: begin
                if (init_s) begin
                    state_d = ST_WAIT_DONE;
                    cnt_d   = DONE_LOAD;
                end else if (cnt_q == 32'd0) begin
                    state_d = ST_ERR;
                    err_d   = ERR_INIT_TO;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_WAIT_DONE: begin
                // DONE takes priority over a simultaneous INIT_B drop.
                if (done_s) begin
                    state_d = ST_RST_HOLD;
                    cnt_d   = HOLD_LOAD;
                end else if (!init_s) begin
                    state_d = ST_ERR;
                    err_d   = ERR_INIT_LOW;
                end else if (cnt_q == 32'd0) begin
                    state_d = ST_ERR;
                    err_d   = ERR_DONE_TO;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_RST_HOLD: begin
                if (cnt_q == 32'd0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_RUN: begin
                if (req_q) begin
                    state_d = ST_PROG;
                    cnt_d   = PROG_LOAD;
                    err_d   = ERR_NONE;
                    retry_d = 3'd0;
                end else if (!done_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_ERR: begin
                if (retry_q < RETRY_MAX) begin
                    state_d = ST_PROG;
                    cnt_d   = PROG_LOAD;
                    retry_d = retry_q + 3'd1;
                end else begin
                    state_d = ST_FAIL;
                end
            end
            ST_FAIL: begin
                if (req_q) begin
                    state_d = ST_PROG;
                    cnt_d   = PROG_LOAD;
                    err_d   = ERR_NONE;
                    retry_d = 3'd0;
                end else begin
                    state_d = ST_FAIL;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 32'd0;
            end
        endcase

        prog_b_d = (state_d != ST_PROG);
        rst_b_d  = (state_d == ST_RUN) ? rst_b_s : 1'b0;
        done_d   = (state_d == ST_RUN);
        init_b_d = (state_d == ST_FAIL) ? 1'b0 : init_s;
        busy_d   = is_busy(state_d);
    end

    // State and registered outputs; reset releases PROG_B and holds RST_B low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 32'd0;
            err_q       <= ERR_NONE;
            retry_q     <= 3'd0;
            prog_prev_q <= 1'b1;
            req_q       <= 1'b0;
            prog_b_q    <= 1'b1;
            rst_b_q     <= 1'b0;
            done_q      <= 1'b0;
            init_b_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            retry_q     <= retry_d;
            prog_prev_q <= prog_prev_d;
            req_q       <= req_d;
            prog_b_q    <= prog_b_d;
            rst_b_q     <= rst_b_d;
            done_q      <= done_d;
            init_b_q    <= init_b_d;
            busy_q      <= busy_d;
        end
    end

    assign prog_b_k7   = prog_b_q;
    assign rst_b_k7    = rst_b_q;
    assign fpga_done   = done_q;
    assign fpga_init_b = init_b_q;
    assign busy        = busy_q;
    assign err_code    = err_q;
    assign retry_cnt   = retry_q;

endmodule
